// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter family (left and right variants).
// Holds operand/counter widths, the control-state encoding and the count clamp helper.
package shift_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  localparam logic [CNT_W-1:0] SHIFT_SAT = CNT_W'(32);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FIN
  } state_e;

  // Counts of 32 or more all saturate; upper bits of the count never wrap back to small values.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [DATA_W-1:0] b);
    return (b >= 32'(DATA_W)) ? SHIFT_SAT : b[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/shl_step.sv
// Single-position left step: logical shift, or rotate when rotate_i feeds bit 31 back into bit 0.
module shl_step
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] res_i,
  input  logic              rotate_i,
  output logic [DATA_W-1:0] res_o
);

  assign res_o = {res_i[DATA_W-2:0], rotate_i & res_i[DATA_W-1]};

endmodule

// File: rtl/shl_iter.sv
// Iterative 32-bit shift-left unit, one bit per clock, start/busy/done handshake.
// Define SHL_ROTATE_EN to honour the rotate input (rotate-left with count B[4:0]).
module shl_iter
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic              rotate,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] Result
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  load_cnt;
  logic [DATA_W-1:0] step_res;
  logic              mode_q;

`ifdef SHL_ROTATE_EN
  logic mode_d;

  // Rotating by 32 is the identity, so rotate mode only keeps the low five count bits.
  assign load_cnt = rotate ? {1'b0, B[4:0]} : clamp_count(B);
`else
  logic unused_rotate;

  assign unused_rotate = rotate;
  assign mode_q        = 1'b0;
  assign load_cnt      = clamp_count(B);
`endif

  shl_step u_step (
    .res_i    (res_q),
    .rotate_i (mode_q),
    .res_o    (step_res)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
`ifdef SHL_ROTATE_EN
    mode_d  = mode_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          res_d   = A;
          cnt_d   = load_cnt;
`ifdef SHL_ROTATE_EN
          mode_d  = rotate;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          res_d = step_res;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SHL_ROTATE_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) mode_q <= 1'b0;
    else        mode_q <= mode_d;
  end
`endif

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == FIN);
  assign Result = res_q;

endmodule

// File: tb/tb_shl_iter.sv
// Self-checking bench for shl_iter: reset, vector table, randomized ops against a
// behavioural model, ignored-start and mid-operation reset sequences.
module tb_shl_iter;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        start = 1'b0;
  logic        rotate = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic        done;
  logic [31:0] Result;

  int n_total = 0;
  int n_pass  = 0;

  shl_iter dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .start  (start),
    .rotate (rotate),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .Result (Result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic bit rot_on(input logic rot);
`ifdef SHL_ROTATE_EN
    return rot;
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural model: what the result is, and how many shift steps it takes.
  function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b, input logic rot);
    int n;
    if (rot_on(rot)) begin
      n = int'(b % 32);
      if (n == 0) return a;
      return (a << n) | (a >> (32 - n));
    end
    if (b >= 32) return 32'h0;
    return a << b;
  endfunction

  function automatic int model_n(input logic [31:0] b, input logic rot);
    if (rot_on(rot)) return int'(b % 32);
    return (b >= 32) ? 32 : int'(b);
  endfunction

  // Runs one operation; reports edge index of done (acceptance edge = 0), busy cycles, done count.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic rot,
                       output logic [31:0] res, output int done_at, output int busy_cnt,
                       output int done_cnt);
    @(negedge clk);
    A = a; B = b; rotate = rot; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = ~a; B = b ^ 32'h5; rotate = ~rot;
    busy_cnt = 0; done_at = -1; done_cnt = 0; res = Result;
    for (int e = 0; e < 40; e++) begin
      if (!busy) break;
      busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = e;
        res = Result;
      end
      @(posedge clk); #1;
    end
    if (done_at < 0) res = Result;
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic rot, input logic [31:0] exp_res, input int exp_n);
    logic [31:0] res;
    int d_at, b_cnt, d_cnt;
    do_op(a, b, rot, res, d_at, b_cnt, d_cnt);
    check({tag, "_result"}, 64'(res), 64'(exp_res));
    check({tag, "_done_edge"}, 64'(d_at), 64'(exp_n + 1));
    check({tag, "_busy_cycles"}, 64'(b_cnt), 64'(exp_n + 2));
    check({tag, "_done_pulses"}, 64'(d_cnt), 64'd1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        rot;
    logic [31:0] exp_res;
    int          exp_n;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] ra, rb, r;
    logic        rr;
    int          dn;
    bit          fin_start;
    bit          done_seen;

    vecs[0] = '{32'h0000_0001, 32'd4,         1'b0, 32'h0000_0010, 4};
    vecs[1] = '{32'hFFFF_FFFF, 32'd0,         1'b0, 32'hFFFF_FFFF, 0};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0100, 1'b0, 32'h0000_0000, 32};
    vecs[3] = '{32'h1234_5678, 32'd31,        1'b0, 32'h0000_0000, 31};
    vecs[4] = '{32'h8000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32};
`ifdef SHL_ROTATE_EN
    vecs[5] = '{32'h8000_0001, 32'd1,         1'b1, 32'h0000_0003, 1};
    vecs[6] = '{32'hA5A5_0F0F, 32'd32,        1'b1, 32'hA5A5_0F0F, 0};
`else
    vecs[5] = '{32'h8000_0001, 32'd1,         1'b1, 32'h0000_0002, 1};
    vecs[6] = '{32'hA5A5_0F0F, 32'd32,        1'b1, 32'h0000_0000, 32};
`endif

    // Reset held with start asserted.
    start = 1'b1; A = 32'hDEAD_BEEF; B = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(Result), 64'd0);
    @(negedge clk);
    start = 1'b0;
    clr_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_release", 64'(busy), 64'd0);

    foreach (vecs[i])
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].rot,
                    vecs[i].exp_res, vecs[i].exp_n);

    for (int k = 0; k < 25; k++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      rr = 1'($urandom_range(0, 1));
      run_and_check($sformatf("rand%0d", k), ra, rb, rr, model_res(ra, rb, rr), model_n(rb, rr));
    end

    // Start while busy and start during FIN are both ignored; input changes do not matter.
    @(negedge clk);
    A = 32'h1; B = 32'd31; rotate = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dn = 0; r = '0; fin_start = 1'b0;
    for (int e = 0; e < 45; e++) begin
      if (fin_start) begin
        check("fin_start_ignored", 64'(busy), 64'd0);
        start = 1'b0;
        break;
      end
      if (done) begin
        dn++;
        r = Result;
        start = 1'b1;
        fin_start = 1'b1;
      end
      if (e == 3) begin A = 32'hF; B = 32'd1; start = 1'b1; end
      if (e == 5) begin start = 1'b0; A = 32'hDEAD_BEEF; B = 32'd2; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    check("busy_start_result", 64'(r), 64'h8000_0000);
    check("busy_start_one_done", 64'(dn), 64'd1);
    check("busy_start_idle", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    A = 32'h1234_5678; B = 32'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) done_seen = 1'b1;
    end
    #1 clr_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_result", 64'(Result), 64'd0);
    repeat (10) begin
      @(posedge clk); #1;
      if (done) done_seen = 1'b1;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    run_and_check("after_abort", 32'h1234_5678, 32'd8, 1'b0, 32'h3456_7800, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shl_iter.md
# shl_iter

Iterative 32-bit logical shift-left unit for the Mini-SRC datapath ALU; the left-direction counterpart of the existing right shifter. It shifts one bit position per clock under a start/busy/done handshake, so that large shift counts are spread over several cycles rather than handled by a wide combinational path. The result is held in a register that the ALU output multiplexer and the Z register load from.

## Interface
- DATA_W, 32, operand and result width (only 32 is supported).
- CNT_W, 6, width of the internal down-counter; holds 0..32.
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only while idle.
- rotate  in  1  selects rotate-left; it has effect only when SHL_ROTATE_EN is defined.
- A  in  32  operand.
- B  in  32  shift count (full 32-bit unsigned).
- busy  out  1  high from the cycle after the start is accepted until done.
- done  out  1  one-cycle pulse; Result is valid from this cycle onward.
- Result  out  32  registered result.

## Operation
- States: IDLE, SHIFT, FIN.
- IDLE, start=1:
  - Load res_q ← A.
  - Load cnt_q ← (B ≥ 32) ? 32 : B[5:0]. In rotate mode, load cnt_q ← B[4:0] instead.
  - Latch the rotate mode bit, then go to SHIFT.
- IDLE, start=0: hold all registers.
- SHIFT, cnt_q ≠ 0:
  - Shift mode: res_q ← {res_q[30:0], 1'b0}.
  - Rotate mode: res_q ← {res_q[30:0], res_q[31]}.
  - In both modes, cnt_q ← cnt_q − 1.
- SHIFT, cnt_q = 0: go to FIN.
- FIN: done=1 for exactly one cycle, then go to IDLE.
- busy = (state ≠ IDLE). done = (state = FIN).
- start is ignored while busy=1. It is not queued.
- start in the same cycle as FIN is also ignored, because FIN is not IDLE.
- A, B and rotate are sampled only on the accepting edge. Later changes do not affect the running operation.
- Result = res_q at all times. Result shows intermediate values while busy and is meaningful only from done onward.
- A count of 0: Result = A, and done is asserted 2 cycles after acceptance.
- A count ≥ 32 in shift mode gives Result = 0 after 32 shift cycles. Bits of B above bit 5 never wrap.

## Timing
- Reset (clr_n=0, asynchronous): state=IDLE, res_q=0, cnt_q=0, mode=0, so busy=0, done=0 and Result=0.
- Reset mid-operation aborts immediately. There is no done pulse, and Result returns to 0.
- Clock edges are counted from edge 0, the edge on which start is sampled in IDLE:
  - busy is high from edge 0 through the edge that leaves FIN.
  - For effective count N, SHIFT occupies N+1 cycles: N shifts plus the exit check.
  - done is high after edge N+1, for one cycle.
- Latency from start to done is N+2 cycles: 2 cycles minimum, 34 maximum.
- Back-to-back operation: the earliest next acceptance is the cycle after done, so the issue interval is N+3.
- Outputs are registered or decoded from state only. There is no combinational path from the inputs to the outputs.

## Configuration
- SHL_ROTATE_EN defined:
  - the rotate input is honoured and latched at acceptance;
  - rotate mode uses count B[4:0], so a count of 32 is effectively 0;
  - bit 31 feeds back into bit 0.
- SHL_ROTATE_EN undefined:
  - the rotate port is present but ignored, and the mode register is absent;
  - the block always performs a logical shift-left with clamped count.

## Structure
- Package shift_pkg holds:
  - DATA_W and CNT_W;
  - the state enum (IDLE, SHIFT, FIN);
  - the SHIFT_SAT constant (32).
- The right-shift variant will reuse shift_pkg.
- One sub-module, shl_step: a combinational single-position step taking (res, rotate) and returning the next res. It is instantiated once, ahead of res_q.

## Test plan
- Reset: hold clr_n=0 with start=1 → busy=0, done=0, Result=0. Release → the block stays IDLE until a start arrives in IDLE.
- A=0x0000_0001, B=4, start → done at start+6 (N+2), Result=0x0000_0010, busy high for exactly 6 cycles.
- A=0xFFFF_FFFF, B=0 → done 2 cycles after start, Result=0xFFFF_FFFF. Repeat with B=0x0000_0100 → 34 cycles, Result=0.
- A=0x8000_0001, B=1, rotate=1, with SHL_ROTATE_EN defined → Result=0x0000_0003. Same stimulus without the macro → Result=0x0000_0002.
- A=0x1, B=31; during busy, pulse start with A=0xF, B=1 and toggle the A/B inputs → second start ignored, Result=0x8000_0000, only one done pulse.
- A=0x1234_5678, B=8; assert clr_n=0 at start+3 → busy=0, Result=0, no done pulse. After release, A=0x1234_5678, B=8, start → Result=0x3456_7800.
